// File: rtl/pipe_adder_gen.sv
// Carry-pipelined two's-complement adder/subtractor.
// The operands are cut into STAGES chunks of CHUNK bits, and one chunk is resolved per clock.
// The carry is registered between stages.
// Each stage keeps only the operand bits that are still to be added (the skew registers)
// and the sum bits already produced (the deskew registers), so no flop is wasted.
// All stages shift together when the output is free or being consumed, and otherwise they hold.
module pipe_adder_gen #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;

  logic             en_s;
  logic [WIDTH-1:0] b_eff_s;
  logic             c0_s;
  logic             ovf_d;
  logic             ovf_q;

  // Global advance enable, plus the effective second operand and carry-in of the incoming beat
  always_comb begin
    en_s    = ~out_valid | out_ready;
    b_eff_s = sub ? ~b : b;
    c0_s    = sub ? 1'b1 : cin;
  end

  assign in_ready = en_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int SW = (k + 1) * CHUNK;

    logic [CHUNK-1:0] ca_s;
    logic [CHUNK-1:0] cb_s;
    logic             ci_s;
    logic             vi_s;
    logic [CHUNK:0]   csum_s;
    logic [SW-1:0]    s_d;
    logic [SW-1:0]    s_q;
    logic             c_d;
    logic             c_q;
    logic             v_d;
    logic             v_q;

    if (k == 0) begin : g_src
      // The first stage takes its chunk, carry-in and valid directly from the ports
      always_comb begin
        ca_s = a[CHUNK-1:0];
        cb_s = b_eff_s[CHUNK-1:0];
        ci_s = c0_s;
        vi_s = in_valid;
      end

      // The first partial sum is just this stage's chunk
      always_comb begin
        if (en_s) begin
          s_d = csum_s[CHUNK-1:0];
        end else begin
          s_d = s_q;
        end
      end
    end else begin : g_src
      // Later stages take the lowest still-pending chunk and the carry from the previous stage
      always_comb begin
        ca_s = g_stage[k-1].g_skew.ua_q[CHUNK-1:0];
        cb_s = g_stage[k-1].g_skew.ub_q[CHUNK-1:0];
        ci_s = g_stage[k-1].c_q;
        vi_s = g_stage[k-1].v_q;
      end

      // Append this chunk above the sum bits already completed upstream
      always_comb begin
        if (en_s) begin
          s_d = {csum_s[CHUNK-1:0], g_stage[k-1].s_q};
        end else begin
          s_d = s_q;
        end
      end
    end

    // Resolve this stage's chunk, and either shift the beat in or hold the stage
    always_comb begin
      csum_s = {1'b0, ca_s} + {1'b0, cb_s} + {{CHUNK{1'b0}}, ci_s};
      if (en_s) begin
        c_d = csum_s[CHUNK];
        v_d = vi_s;
      end else begin
        c_d = c_q;
        v_d = v_q;
      end
    end

    // Stage register: partial sum, carry and valid bit
    always_ff @(posedge clk) begin
      if (rst) begin
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else begin
        s_q <= s_d;
        c_q <= c_d;
        v_q <= v_d;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      localparam int UW = WIDTH - SW;

      logic [UW-1:0] ua_s;
      logic [UW-1:0] ub_s;
      logic [UW-1:0] ua_d;
      logic [UW-1:0] ua_q;
      logic [UW-1:0] ub_d;
      logic [UW-1:0] ub_q;

      if (k == 0) begin : g_in
        // The upper operand chunks come straight from the ports
        always_comb begin
          ua_s = a[WIDTH-1:CHUNK];
          ub_s = b_eff_s[WIDTH-1:CHUNK];
        end
      end else begin : g_in
        // Drop the chunk consumed by this stage and forward the rest
        always_comb begin
          ua_s = g_stage[k-1].g_skew.ua_q[UW+CHUNK-1:CHUNK];
          ub_s = g_stage[k-1].g_skew.ub_q[UW+CHUNK-1:CHUNK];
        end
      end

      // The skew registers shift with the pipeline and hold on a stall
      always_comb begin
        if (en_s) begin
          ua_d = ua_s;
          ub_d = ub_s;
        end else begin
          ua_d = ua_q;
          ub_d = ub_q;
        end
      end

      // Skew register: the operand bits not yet added
      always_ff @(posedge clk) begin
        if (rst) begin
          ua_q <= '0;
          ub_q <= '0;
        end else begin
          ua_q <= ua_d;
          ub_q <= ub_d;
        end
      end
    end
  end

  // Signed overflow is set when the operand signs agree but the sign of the result differs
  always_comb begin
    if (en_s) begin
      ovf_d = (g_stage[STAGES-1].ca_s[CHUNK-1] == g_stage[STAGES-1].cb_s[CHUNK-1]) &&
              (g_stage[STAGES-1].csum_s[CHUNK-1] != g_stage[STAGES-1].ca_s[CHUNK-1]);
    end else begin
      ovf_d = ovf_q;
    end
  end

  // The overflow flag is registered alongside the last stage
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign carry     = g_stage[STAGES-1].c_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipe_adder_gen.sv
// Self-checking bench for pipe_adder_gen.
// The main instance (16-bit, 4 stages) runs:
//   - a table of directed vectors,
//   - a backpressure sequence,
//   - a mid-stream reset sequence,
//   - random traffic.
// Three more instances, (8,1), (8,8) and (32,4), run random traffic against the same arithmetic model.
module tb_pipe_adder_gen;

  typedef struct {
    longint s;
    bit     c;
    bit     v;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        v;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int retired = 0;
  bit last_acc;
  bit last_rdy;

  logic        m_rst, m_in_valid, m_in_ready, m_cin, m_sub;
  logic        m_out_valid, m_out_ready, m_carry, m_overflow;
  logic [15:0] m_a, m_b, m_sum;
  res_t        mq[$];
  vec_t        tbl[11];

  pipe_adder_gen #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst(m_rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .cin(m_cin), .sub(m_sub),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .sum(m_sum), .carry(m_carry), .overflow(m_overflow)
  );

  // Arithmetic reference: integer add/subtract, with signed range checking for overflow
  function automatic res_t model(input int w, input longint ua, input longint ub,
                                 input bit ci, input bit sb);
    res_t   r;
    longint m, half, sa, sbv, sr, tot;
    m    = longint'(1) << w;
    half = m / 2;
    sa   = (ua >= half) ? ua - m : ua;
    sbv  = (ub >= half) ? ub - m : ub;
    if (sb) begin
      r.s = (ua - ub + m) % m;
      r.c = (ua >= ub);
      sr  = sa - sbv;
    end else begin
      tot = ua + ub + longint'(ci);
      r.s = tot % m;
      r.c = (tot >= m);
      sr  = sa + sbv + longint'(ci);
    end
    r.v = (sr >= half) || (sr < -half);
    return r;
  endfunction

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Score the current (settled) cycle on the main instance, then advance one clock
  task automatic cycle();
    res_t        e;
    bit          stall, was_rst;
    logic [15:0] ps;
    logic        pc, pv;
    #1;
    was_rst  = m_rst;
    stall    = m_out_valid && !m_out_ready;
    ps       = m_sum;
    pc       = m_carry;
    pv       = m_overflow;
    last_rdy = m_in_ready;
    last_acc = 1'b0;
    if (m_rst) begin
      mq.delete();
    end else begin
      chk("in_ready", longint'(m_in_ready), longint'(!stall));
      if (m_out_valid && m_out_ready) begin
        chk("beat_pending", longint'(mq.size() > 0), 1);
        if (mq.size() > 0) begin
          e = mq.pop_front();
          chk("sum", longint'(m_sum), e.s);
          chk("carry", longint'(m_carry), longint'(e.c));
          chk("overflow", longint'(m_overflow), longint'(e.v));
          retired++;
        end
      end
      if (m_in_valid && m_in_ready) begin
        mq.push_back(model(16, longint'(m_a), longint'(m_b), m_cin, m_sub));
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (stall && !was_rst) begin
      chk("hold_valid", longint'(m_out_valid), 1);
      chk("hold_sum", longint'(m_sum), longint'(ps));
      chk("hold_carry", longint'(m_carry), longint'(pc));
      chk("hold_overflow", longint'(m_overflow), longint'(pv));
    end
  endtask

  // Apply one beat with no backpressure, then check its latency and its result
  task automatic directed(input vec_t v, input string nm);
    int lat;
    m_a = v.a; m_b = v.b; m_cin = v.cin; m_sub = v.sub;
    m_in_valid = 1'b1; m_out_ready = 1'b1;
    cycle();
    m_in_valid = 1'b0;
    lat = 1;
    while (!m_out_valid && lat < 20) begin
      cycle();
      lat++;
    end
    chk({nm, "_latency"}, longint'(lat), 4);
    chk({nm, "_sum"}, longint'(m_sum), longint'(v.s));
    chk({nm, "_carry"}, longint'(m_carry), longint'(v.c));
    chk({nm, "_overflow"}, longint'(m_overflow), longint'(v.v));
    cycle();
  endtask

  initial begin
    int   cyc, lowcnt, r0, i, t;
    vec_t v;
    logic [15:0] ba[8], bb[8];
    logic        bc[8], bs[8];

    tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[5]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[6]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[8]  = '{16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    tbl[9]  = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0};
    tbl[10] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};

    m_rst = 1'b1; m_in_valid = 1'b0; m_out_ready = 1'b1;
    m_a = 16'h0000; m_b = 16'h0000; m_cin = 1'b0; m_sub = 1'b0;
    #1;
    cycle();
    cycle();
    chk("rst_out_valid", longint'(m_out_valid), 0);
    chk("rst_sum", longint'(m_sum), 0);
    chk("rst_carry", longint'(m_carry), 0);
    chk("rst_overflow", longint'(m_overflow), 0);
    chk("rst_in_ready", longint'(m_in_ready), 1);
    m_rst = 1'b0;

    for (int k = 0; k < 11; k++) begin
      directed(tbl[k], $sformatf("vec%0d", k));
    end

    // Backpressure: 8 beats offered back to back, with out_ready low for 3 cycles once the pipe is full
    for (int k = 0; k < 8; k++) begin
      ba[k] = 16'($urandom); bb[k] = 16'($urandom);
      bc[k] = 1'($urandom);  bs[k] = 1'($urandom);
    end
    r0 = retired; i = 0; cyc = 0; lowcnt = 0;
    while (i < 8 && cyc < 40) begin
      m_in_valid = 1'b1;
      m_a = ba[i]; m_b = bb[i]; m_cin = bc[i]; m_sub = bs[i];
      m_out_ready = !(cyc >= 5 && cyc <= 7);
      cycle();
      if (last_acc) i++;
      if (!last_rdy) lowcnt++;
      cyc++;
    end
    m_in_valid = 1'b0; m_out_ready = 1'b1;
    repeat (8) cycle();
    chk("bp_in_ready_low_cycles", longint'(lowcnt), 3);
    chk("bp_retired", longint'(retired - r0), 8);
    chk("bp_queue_empty", longint'(mq.size()), 0);

    // Reset while three beats are in flight
    for (int k = 0; k < 3; k++) begin
      m_in_valid = 1'b1; m_a = 16'($urandom); m_b = 16'($urandom);
      m_cin = 1'($urandom); m_sub = 1'($urandom);
      cycle();
    end
    m_in_valid = 1'b0; m_rst = 1'b1;
    cycle();
    chk("midrst_out_valid", longint'(m_out_valid), 0);
    chk("midrst_sum", longint'(m_sum), 0);
    chk("midrst_carry", longint'(m_carry), 0);
    chk("midrst_overflow", longint'(m_overflow), 0);
    m_rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("midrst_no_stale", longint'(m_out_valid), 0);
    end
    v = '{16'h1234, 16'h0FF0, 1'b0, 1'b1, 16'h0244, 1'b1, 1'b0};
    directed(v, "after_rst");

    // Random traffic with random backpressure
    for (int n = 0; n < 300; n++) begin
      m_in_valid = 1'($urandom); m_a = 16'($urandom); m_b = 16'($urandom);
      m_cin = 1'($urandom); m_sub = 1'($urandom);
      m_out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    m_in_valid = 1'b0; m_out_ready = 1'b1;
    repeat (8) cycle();
    chk("rand_queue_empty", longint'(mq.size()), 0);

    t = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    chk("sweep_finished",
        longint'(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int W = (g == 0) ? 8 : ((g == 1) ? 8 : 32);
    localparam int S = (g == 0) ? 1 : ((g == 1) ? 8 : 4);

    logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, carry, overflow;
    logic [W-1:0] a, b, sum;
    bit           done = 1'b0;
    res_t         q[$];

    pipe_adder_gen #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .carry(carry), .overflow(overflow)
    );

    // Score one settled cycle of this instance, then advance one clock
    task automatic score();
      res_t e;
      #1;
      chk($sformatf("w%0d_s%0d_in_ready", W, S), longint'(in_ready),
          longint'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        chk($sformatf("w%0d_s%0d_beat_pending", W, S), longint'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk($sformatf("w%0d_s%0d_sum", W, S), longint'(sum), e.s);
          chk($sformatf("w%0d_s%0d_carry", W, S), longint'(carry), longint'(e.c));
          chk($sformatf("w%0d_s%0d_overflow", W, S), longint'(overflow), longint'(e.v));
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(W, longint'(a), longint'(b), cin, sub));
      end
      @(posedge clk);
      #1;
    endtask

    initial begin
      res_t e;
      int   acc, guard, lat;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // One isolated beat to measure the unstalled latency
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'b1;
      e = model(W, longint'(a), longint'(b), cin, sub);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk($sformatf("w%0d_s%0d_latency", W, S), longint'(lat), longint'(S));
      chk($sformatf("w%0d_s%0d_lat_sum", W, S), longint'(sum), e.s);
      chk($sformatf("w%0d_s%0d_lat_carry", W, S), longint'(carry), longint'(e.c));
      @(posedge clk);
      #1;

      acc = 0; guard = 0;
      while (acc < 1000 && guard < 20000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        if (in_valid && (!out_valid || out_ready)) acc++;
        score();
        guard++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (S + 4) score();
      chk($sformatf("w%0d_s%0d_beats_accepted", W, S), longint'(acc), 1000);
      chk($sformatf("w%0d_s%0d_queue_empty", W, S), longint'(q.size()), 0);
      done = 1'b1;
    end
  end

endmodule
